// File: rtl/spm_pkg.sv
// Shared types for the SPM read streamer: FSM states, command record and counter sizing.
// The optional stride feature (macro SPM_RD_STRIDE_EN) is handled in spm_rd_streamer.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int SPM_ADDR_W     = 12;
    localparam int SPM_LEN_W      = 13;
    localparam int SPM_FIFO_DEPTH = 8;
    localparam int CNT_W          = $clog2(SPM_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [SPM_ADDR_W-1:0] base;
        logic [SPM_LEN_W-1:0]  len;
        logic [SPM_ADDR_W-1:0] stride;
    } spm_rd_cmd_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spm_rd_streamer_chk.sv
// Safety checks for the read streamer: the credit scheme must never overflow the output FIFO.
module spm_rd_streamer_chk #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             i_push,
    input logic             i_full,
    input logic [CNT_W-1:0] i_credit,
    input logic [CNT_W-1:0] i_fifo_cnt
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && i_full));
    a_credit_max:  assert property (@(posedge clk) disable iff (rst) i_credit <= CNT_W'(FIFO_DEPTH));
    a_credit_cov:  assert property (@(posedge clk) disable iff (rst) i_credit >= i_fifo_cnt);

endmodule

// File: rtl/spm_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is dropped.
module spm_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign o_empty = (count_q == CNT_W'(0));
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        do_push_s = i_push & ~o_full;
        do_pop_s  = i_pop & ~o_empty;
        wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_s);
        rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_s);
        count_d   = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/spm_rd_streamer.sv
// Burst read front end for one URAM scratchpad port: issues reads, absorbs RD_LAT, streams data out.
// Optional macro SPM_RD_STRIDE_EN adds i_cmd_stride as the per-word address step (default step 1).
module spm_rd_streamer
    import spm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_base,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
`ifdef SPM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] i_cmd_stride,
`endif
    output logic [ADDR_WIDTH-1:0] o_spm_addr,
    output logic                  o_spm_en,
    output logic                  o_spm_wr_en,
    input  logic [DATA_WIDTH-1:0] i_spm_rd_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_done
);

    localparam int CRD_W = cnt_width(FIFO_DEPTH);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  en_q, en_d;
    logic                  tag_q, tag_d;
    logic [RD_LAT-1:0]     vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]     last_sr_q, last_sr_d;
    logic [CRD_W-1:0]      credit_q, credit_d;
    logic                  zdone_q, zdone_d;

    logic [ADDR_WIDTH-1:0] cmd_step_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  credit_ok_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [CRD_W-1:0]      fifo_cnt_s;
    logic [DATA_WIDTH:0]   fifo_dout_s;

`ifdef SPM_RD_STRIDE_EN
    assign cmd_step_s = i_cmd_stride;
`else
    assign cmd_step_s = ADDR_WIDTH'(1);
`endif

    assign o_cmd_ready = (state_q == IDLE);
    assign o_spm_addr  = addr_q;
    assign o_spm_en    = en_q;
    assign o_spm_wr_en = 1'b0;
    assign o_valid     = ~fifo_empty_s;
    assign o_data      = fifo_dout_s[DATA_WIDTH-1:0];
    assign o_last      = o_valid & fifo_dout_s[DATA_WIDTH];
    assign pop_s       = o_valid & i_ready;
    assign push_s      = vld_sr_q[RD_LAT-1];
    assign o_done      = zdone_q | (pop_s & o_last);

    // A slot freed by this cycle's pop may be reused at once: its replacement lands RD_LAT+1 cycles later.
    assign credit_ok_s = ((credit_q - CRD_W'(pop_s)) < CRD_W'(FIFO_DEPTH));

    // Burst FSM: issue decisions, address generation and credit accounting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        step_d      = step_q;
        remain_d    = remain_q;
        en_d        = 1'b0;
        tag_d       = 1'b0;
        zdone_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    step_d = cmd_step_s;
                    if (i_cmd_len == LEN_WIDTH'(0)) begin
                        zdone_d = 1'b1;
                    end else begin
                        en_d        = 1'b1;
                        tag_d       = (i_cmd_len == LEN_WIDTH'(1));
                        addr_d      = i_cmd_base;
                        next_addr_d = i_cmd_base + cmd_step_s;
                        remain_d    = i_cmd_len - LEN_WIDTH'(1);
                        state_d     = (i_cmd_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
                    end
                end else begin
                    zdone_d = 1'b0;
                end
            end
            ISSUE: begin
                if (credit_ok_s) begin
                    en_d        = 1'b1;
                    tag_d       = (remain_q == LEN_WIDTH'(1));
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + step_q;
                    remain_d    = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    en_d = 1'b0;
                end
            end
            DRAIN: begin
                if (pop_s && o_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        credit_d = credit_q + CRD_W'(en_d) - CRD_W'(pop_s);
    end

    // Read-latency tracker: a read enabled in cycle t is captured in cycle t+RD_LAT.
    always_comb begin
        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = en_q;
        last_sr_d[0] = tag_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= ADDR_WIDTH'(0);
            next_addr_q <= ADDR_WIDTH'(0);
            step_q      <= ADDR_WIDTH'(1);
            remain_q    <= LEN_WIDTH'(0);
            en_q        <= 1'b0;
            tag_q       <= 1'b0;
            vld_sr_q    <= RD_LAT'(0);
            last_sr_q   <= RD_LAT'(0);
            credit_q    <= CRD_W'(0);
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            step_q      <= step_d;
            remain_q    <= remain_d;
            en_q        <= en_d;
            tag_q       <= tag_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            credit_q    <= credit_d;
            zdone_q     <= zdone_d;
        end
    end

    spm_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CRD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (push_s),
        .i_data  ({last_sr_q[RD_LAT-1], i_spm_rd_data}),
        .i_pop   (pop_s),
        .o_data  (fifo_dout_s),
        .o_empty (fifo_empty_s),
        .o_full  (fifo_full_s),
        .o_count (fifo_cnt_s)
    );

    spm_rd_streamer_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CRD_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_push     (push_s),
        .i_full     (fifo_full_s),
        .i_credit   (credit_q),
        .i_fifo_cnt (fifo_cnt_s)
    );

endmodule

// File: tb/tb_spm_rd_streamer.sv
// Directed bench for spm_rd_streamer: SPM modelled as an RD_LAT read pipe with mem[i]=i.
module tb_spm_rd_streamer;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int RL = 3;
    localparam int FD = 8;
    localparam int LW = 13;

    logic          clk;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_base;
    logic [LW-1:0] i_cmd_len;
    logic [AW-1:0] i_cmd_stride;
    logic [AW-1:0] o_spm_addr;
    logic          o_spm_en;
    logic          o_spm_wr_en;
    logic [DW-1:0] i_spm_rd_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_done;

    spm_rd_streamer #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LAT (RL), .FIFO_DEPTH (FD), .LEN_WIDTH (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_base    (i_cmd_base),
        .i_cmd_len     (i_cmd_len),
`ifdef SPM_RD_STRIDE_EN
        .i_cmd_stride  (i_cmd_stride),
`endif
        .o_spm_addr    (o_spm_addr),
        .o_spm_en      (o_spm_en),
        .o_spm_wr_en   (o_spm_wr_en),
        .i_spm_rd_data (i_spm_rd_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPM model: mem[a] = a, RD_LAT cycles after the enable edge; poison otherwise.
    logic [DW-1:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= o_spm_en ? DW'(o_spm_addr) : 64'hDEAD_0000_0000_0000;
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign i_spm_rd_data = pipe[RL-1];

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          dn;
        int            c;
    } word_t;

    word_t         wq[$];
    logic [AW-1:0] aq[$];
    int            done_cnt;
    int            done_cyc;
    int            first_vcyc;
    int            acc_cyc;
    int            n_total = 0;
    int            n_bad   = 0;
    bit            rnd_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && first_vcyc < 0) first_vcyc = cyc;
            if (o_valid && i_ready) wq.push_back('{o_data, o_last, o_done, cyc});
            if (o_spm_en) aq.push_back(o_spm_addr);
            if (o_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        aq.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        first_vcyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input logic [AW-1:0] stride);
        int w = 0;
        while (!o_cmd_ready && w < 200) begin
            step();
            w++;
        end
        chk("cmd_ready_wait", 64'(o_cmd_ready), 64'd1);
        i_cmd_valid  = 1'b1;
        i_cmd_base   = base;
        i_cmd_len    = len;
        i_cmd_stride = stride;
        acc_cyc      = cyc;
        step();
        i_cmd_valid  = 1'b0;
        i_cmd_base   = AW'($urandom);
        i_cmd_len    = LW'($urandom);
        i_cmd_stride = AW'($urandom);
    endtask

    task automatic wait_done(input int max_cyc);
        int w = 0;
        while (done_cnt < 1 && w < max_cyc) begin
            step();
            w++;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
    endtask

    task automatic check_burst(input string tag, input logic [AW-1:0] base, input int len,
                               input logic [AW-1:0] stp);
        logic [AW-1:0] a;
        a = base;
        chk({tag, "_count"}, 64'(wq.size()), 64'(len));
        for (int k = 0; k < len && k < wq.size(); k++) begin
            chk({tag, "_data"}, wq[k].d, 64'(a));
            chk({tag, "_last"}, 64'(wq[k].l), 64'(k == len - 1));
            chk({tag, "_done"}, 64'(wq[k].dn), 64'(k == len - 1));
            a = a + stp;
        end
    endtask

    initial begin
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_base = '0; i_cmd_len = '0;
        i_cmd_stride = '0; i_ready = 1'b0;
        for (int k = 0; k < RL; k++) pipe[k] = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_spm_en", 64'(o_spm_en), 64'd0);
        chk("rst_spm_addr", 64'(o_spm_addr), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_wr_en", 64'(o_spm_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: simple burst at full rate
        clear_mon(); i_ready = 1'b1;
        send_cmd(12'h010, 13'd4, 12'd1);
        wait_done(100);
        check_burst("t1", 12'h010, 4, 12'd1);
        chk("t1_latency", 64'(first_vcyc - acc_cyc), 64'(RL + 2));
        if (wq.size() == 4) chk("t1_back2back", 64'(wq[3].c - wq[0].c), 64'd3);
        step();

        // 2: address wrap
        clear_mon();
        send_cmd(12'hFFE, 13'd4, 12'd1);
        wait_done(100);
        chk("t2_addr_n", 64'(aq.size()), 64'd4);
        if (aq.size() == 4) begin
            chk("t2_addr0", 64'(aq[0]), 64'hFFE);
            chk("t2_addr1", 64'(aq[1]), 64'hFFF);
            chk("t2_addr2", 64'(aq[2]), 64'h000);
            chk("t2_addr3", 64'(aq[3]), 64'h001);
        end
        check_burst("t2", 12'hFFE, 4, 12'd1);
        step();

        // 3: consumer stall, credits exhausted
        clear_mon(); i_ready = 1'b0;
        send_cmd(12'h200, 13'd32, 12'd1);
        repeat (20) step();
        chk("t3_issued_stall", 64'(aq.size()), 64'(FD));
        chk("t3_valid_hold", 64'(o_valid), 64'd1);
        chk("t3_head_hold", o_data, 64'h200);
        chk("t3_none_popped", 64'(wq.size()), 64'd0);
        i_ready = 1'b1;
        wait_done(200);
        check_burst("t3", 12'h200, 32, 12'd1);
        chk("t3_issued_total", 64'(aq.size()), 64'd32);
        step();

        // 4: zero-length command
        clear_mon();
        send_cmd(12'h055, 13'd0, 12'd1);
        repeat (8) step();
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);
        chk("t4_done_cyc", 64'(done_cyc - acc_cyc), 64'd1);
        chk("t4_no_en", 64'(aq.size()), 64'd0);
        chk("t4_no_valid", 64'(first_vcyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_ready", 64'(o_cmd_ready), 64'd1);

        // 5: reset in the middle of a burst
        clear_mon();
        send_cmd(12'h300, 13'd32, 12'd1);
        for (int w = 0; w < 100 && aq.size() < 10; w++) step();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("t5_spm_en", 64'(o_spm_en), 64'd0);
        chk("t5_spm_addr", 64'(o_spm_addr), 64'd0);
        chk("t5_valid", 64'(o_valid), 64'd0);
        chk("t5_last", 64'(o_last), 64'd0);
        chk("t5_done", 64'(o_done), 64'd0);
        @(posedge clk); #1;
        clear_mon();
        send_cmd(12'h100, 13'd2, 12'd1);
        wait_done(100);
        repeat (10) step();
        check_burst("t5", 12'h100, 2, 12'd1);

`ifdef SPM_RD_STRIDE_EN
        // 6a: strided burst
        clear_mon();
        send_cmd(12'h000, 13'd3, 12'd4);
        wait_done(100);
        check_burst("t6", 12'h000, 3, 12'd4);
        step();
`endif

        // 6b: random-ready soak against the address model
        rnd_ready = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            logic [AW-1:0] base;
            logic [AW-1:0] stp;
            int            len;
            base = AW'($urandom_range(0, 4095));
            len  = $urandom_range(0, 12);
`ifdef SPM_RD_STRIDE_EN
            stp  = AW'($urandom_range(0, 15));
`else
            stp  = AW'(1);
`endif
            clear_mon();
            send_cmd(base, LW'(len), stp);
            wait_done(400);
            check_burst("soak", base, len, stp);
            if (n_bad > 20) break;
        end
        rnd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
